// File: rtl/out_spike_classifier.sv
// Output-layer spike classifier: counts per-neuron spikes over an image
// window, then scans the counters and reports the winning neuron.
module out_spike_classifier #(
  parameter int N       = 8,
  parameter int CNT_W   = 8,
  parameter int T_STEPS = 350,
  parameter int TU_W    = 16,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_core_img,
  input  logic               valid_op_nub,
  input  logic [N-1:0]       spike_op_nub,
  output logic               class_valid,
  output logic [ID_W-1:0]    class_id,
  output logic [CNT_W-1:0]   class_count,
  output logic               no_spike,
  output logic               busy,
  output logic               err_late,
  output logic [N*CNT_W-1:0] spike_counts
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    REPORT
  } state_t;

  localparam logic [TU_W-1:0]  TU_LAST  = TU_W'(T_STEPS - 1);
  localparam logic [ID_W-1:0]  IDX_LAST = ID_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt [N];
  logic [TU_W-1:0]   tu_cnt;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   best_id;
  logic [CNT_W-1:0]  best_cnt;
  logic              last_tu;
  logic              last_idx;

  assign last_tu  = (tu_cnt == TU_LAST);
  assign last_idx = (idx == IDX_LAST);
  assign busy     = (state == ACCUM) || (state == SCAN);

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign spike_counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_core_img) begin
      state_nxt = ACCUM;
    end else begin
      unique case (state)
        IDLE:   state_nxt = IDLE;
        ACCUM:  if (valid_op_nub && last_tu) state_nxt = SCAN;
        SCAN:   if (last_idx) state_nxt = REPORT;
        REPORT: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      tu_cnt      <= '0;
      idx         <= '0;
      best_id     <= '0;
      best_cnt    <= '0;
      class_valid <= 1'b0;
      class_id    <= '0;
      class_count <= '0;
      no_spike    <= 1'b0;
      err_late    <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (start_core_img) begin
        // a new image also cancels any scan/report still in flight
        for (int i = 0; i < N; i++) cnt[i] <= '0;
        tu_cnt      <= '0;
        idx         <= '0;
        best_id     <= '0;
        best_cnt    <= '0;
        class_id    <= '0;
        class_count <= '0;
        no_spike    <= 1'b0;
        err_late    <= 1'b0;
      end else begin
        if (valid_op_nub && state != ACCUM) err_late <= 1'b1;
        unique case (state)
          ACCUM: begin
            if (valid_op_nub) begin
              for (int i = 0; i < N; i++) begin
                if (spike_op_nub[i] && cnt[i] != CNT_MAX)
                  cnt[i] <= cnt[i] + CNT_W'(1);
              end
              tu_cnt <= tu_cnt + TU_W'(1);
              if (last_tu) begin
                idx      <= '0;
                best_id  <= '0;
                best_cnt <= '0;
              end
            end
          end
          SCAN: begin
            // strict compare keeps the lowest index on ties
            if (cnt[idx] > best_cnt) begin
              best_cnt <= cnt[idx];
              best_id  <= idx;
            end
            idx <= idx + ID_W'(1);
          end
          REPORT: begin
            class_valid <= 1'b1;
            class_count <= best_cnt;
            class_id    <= (best_cnt == '0) ? '0 : best_id;
            no_spike    <= (best_cnt == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_out_spike_classifier.sv
// Scoreboard bench: two classifier configurations share one stimulus
// stream; a per-image reference model predicts labels and counters.
module tb_out_spike_classifier;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [7:0]  spk;

  logic        cv_a, ns_a, busy_a, err_a;
  logic        cv_b, ns_b, busy_b, err_b;
  logic [2:0]  cid_a, cid_b;
  logic [7:0]  ccnt_a;
  logic [1:0]  ccnt_b;
  logic [63:0] sc_a;
  logic [15:0] sc_b;

  out_spike_classifier #(
    .N(8), .CNT_W(8), .T_STEPS(4), .TU_W(16), .ID_W(3)
  ) dut_a (
    .clk(clk), .rst(rst), .start_core_img(start),
    .valid_op_nub(valid), .spike_op_nub(spk),
    .class_valid(cv_a), .class_id(cid_a), .class_count(ccnt_a),
    .no_spike(ns_a), .busy(busy_a), .err_late(err_a),
    .spike_counts(sc_a)
  );

  out_spike_classifier #(
    .N(8), .CNT_W(2), .T_STEPS(5), .TU_W(16), .ID_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start_core_img(start),
    .valid_op_nub(valid), .spike_op_nub(spk),
    .class_valid(cv_b), .class_id(cid_b), .class_count(ccnt_b),
    .no_spike(ns_b), .busy(busy_b), .err_late(err_b),
    .spike_counts(sc_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k;
    int id;
    int cnt;
    int ns;
    int at;
  } req_t;
  req_t q[$];

  int mc [2][8];
  int mtu [2];
  bit macc [2];
  bit merr [2];

  function automatic int tsteps(int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? 255 : 3;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model_vec(int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (k == 0) v[i*8 +: 8] = 8'(mc[k][i]);
      else        v[i*2 +: 2] = 2'(mc[k][i]);
    end
    return v;
  endfunction

  task automatic model_clear(int k, int e, bit arm);
    for (int i = 0; i < 8; i++) mc[k][i] = 0;
    mtu[k]  = 0;
    macc[k] = arm;
    merr[k] = 0;
    for (int j = q.size() - 1; j >= 0; j--)
      if (q[j].k == k && q[j].at >= e) q.delete(j);
  endtask

  task automatic model_finish(int k, int e);
    req_t r;
    int bc, bi;
    bc = 0;
    bi = 0;
    for (int i = 0; i < 8; i++)
      if (mc[k][i] > bc) begin
        bc = mc[k][i];
        bi = i;
      end
    r.k   = k;
    r.id  = bi;
    r.cnt = bc;
    r.ns  = (bc == 0);
    r.at  = e + 8 + 1;
    q.push_back(r);
  endtask

  // drive one cycle of inputs, update the model, check state after the edge
  task automatic apply(bit s, bit v, bit r, logic [7:0] sp);
    int e;
    rst   = r;
    start = s;
    valid = v;
    spk   = sp;
    e = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (r) model_clear(k, e, 1'b0);
      else if (s) model_clear(k, e, 1'b1);
      else if (v) begin
        if (macc[k]) begin
          for (int i = 0; i < 8; i++)
            if (sp[i] && mc[k][i] < cmax(k)) mc[k][i]++;
          mtu[k]++;
          if (mtu[k] == tsteps(k)) begin
            model_finish(k, e);
            macc[k] = 0;
          end
        end else begin
          merr[k] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("err_late_a", 64'(err_a), 64'(merr[0]));
    chk("err_late_b", 64'(err_b), 64'(merr[1]));
    chk("counts_a", sc_a, model_vec(0));
    chk("counts_b", 64'(sc_b), model_vec(1));
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_cv_a"}, 64'(cv_a), 0);
    chk({tag, "_cid_a"}, 64'(cid_a), 0);
    chk({tag, "_ccnt_a"}, 64'(ccnt_a), 0);
    chk({tag, "_ns_a"}, 64'(ns_a), 0);
    chk({tag, "_busy_a"}, 64'(busy_a), 0);
    chk({tag, "_err_a"}, 64'(err_a), 0);
    chk({tag, "_cv_b"}, 64'(cv_b), 0);
    chk({tag, "_busy_b"}, 64'(busy_b), 0);
    chk({tag, "_err_b"}, 64'(err_b), 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int f;
      f = -1;
      if ((k == 0) ? cv_a : cv_b) begin
        for (int j = 0; j < q.size(); j++)
          if (f < 0 && q[j].k == k) f = j;
        if (f < 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_class_valid dut%0d: got 1 expected 0 (cycle %0d)",
                   k, cyc);
        end else begin
          chk("sb_at", 64'(cyc), 64'(q[f].at));
          chk("sb_id", (k == 0) ? 64'(cid_a) : 64'(cid_b), 64'(q[f].id));
          chk("sb_cnt", (k == 0) ? 64'(ccnt_a) : 64'(ccnt_b), 64'(q[f].cnt));
          chk("sb_ns", (k == 0) ? 64'(ns_a) : 64'(ns_b), 64'(q[f].ns));
          q.delete(f);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; spk = '0;
    @(negedge clk);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk_zero("reset");
    idle(2);

    // neuron 5 every step, neuron 2 on steps 1-2
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t1_busy", 64'(busy_a), 1);
    apply(1'b0, 1'b1, 1'b0, 8'h24);
    apply(1'b0, 1'b1, 1'b0, 8'h24);
    apply(1'b0, 1'b1, 1'b0, 8'h20);
    apply(1'b0, 1'b1, 1'b0, 8'h20);
    idle(12);
    chk("t1_id", 64'(cid_a), 5);
    chk("t1_cnt", 64'(ccnt_a), 4);
    chk("t1_ns", 64'(ns_a), 0);
    chk("t1_busy_after", 64'(busy_a), 0);

    // tie between neurons 3 and 6
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'h48);
    apply(1'b0, 1'b1, 1'b0, 8'h48);
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'h48);
    idle(12);
    chk("tie_id", 64'(cid_a), 3);
    chk("tie_cnt", 64'(ccnt_a), 3);

    // silent window
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 8'h00);
    idle(12);
    chk("quiet_ns", 64'(ns_a), 1);
    chk("quiet_id", 64'(cid_a), 0);
    chk("quiet_cnt", 64'(ccnt_a), 0);

    // saturation in the 2-bit, 5-step instance
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 8'h02);
    chk("sat_cnt1", 64'(sc_b[3:2]), 3);
    idle(12);
    chk("sat_id", 64'(cid_b), 1);
    chk("sat_cnt", 64'(ccnt_b), 3);

    // restart after two valids; window needs four more
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'hFF);
    apply(1'b0, 1'b1, 1'b0, 8'hFF);
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_clear", sc_a, 0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 8'h81);
    chk("restart_busy", 64'(busy_a), 1);
    apply(1'b0, 1'b1, 1'b0, 8'h80);
    idle(12);
    chk("restart_id", 64'(cid_a), 7);

    // late valid while idle, then start colliding with valid
    apply(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("late_err", 64'(err_a), 1);
    apply(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("start_valid_err", 64'(err_a), 0);
    chk("start_valid_cnt", sc_a, 0);
    idle(2);

    // reset in the middle of a scan
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 8'h10);
    idle(3);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk_zero("scan_rst");
    idle(14);

    // random images with random gaps
    for (int img = 0; img < 8; img++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00);
      for (int s = 0; s < 5; s++) begin
        idle($urandom_range(0, 2));
        apply(1'b0, 1'b1, 1'b0, 8'($urandom & $urandom));
      end
      idle(14);
    end

    chk("queue_empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_spike_classifier.md
Name: out_spike_classifier

Overview:
- Downstream consumer of the output neuron block. It takes one N-bit output spike vector per time unit, qualified by valid_op_nub.
- Accumulates per-neuron spike counts over a fixed window of T_STEPS time units per image.
- At the end of the window, serially scans the counters and reports the winning output neuron (class label) with a one-cycle handshake pulse.
- Its result is the per-image inference/labelling output of the SNN core.

Parameters:
- N, 8, number of output neurons (width of the spike vector)
- CNT_W, 8, width of each per-neuron spike counter (saturating)
- T_STEPS, 350, number of valid time units per image window (must be ≥1)
- TU_W, 16, width of the time-unit counter (2^TU_W > T_STEPS)
- ID_W, 3, width of the class index (2^ID_W ≥ N)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_core_img  in  1  new-image pulse; clears and arms the block
- valid_op_nub  in  1  one-cycle pulse: spike_op_nub holds this time unit's result
- spike_op_nub  in  N  output spikes of the current time unit, bit i = neuron i
- class_valid  out  1  one-cycle pulse: class outputs are final
- class_id  out  ID_W  index of the winning neuron
- class_count  out  CNT_W  spike count of the winner
- no_spike  out  1  no neuron spiked during the window
- busy  out  1  high in ACCUM and SCAN
- err_late  out  1  sticky: valid_op_nub arrived outside ACCUM
- spike_counts  out  N*CNT_W  live counters; neuron i at [(i+1)*CNT_W-1 : i*CNT_W]

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - All counters, tu_cnt, scan index, best registers cleared.
  - class_valid=0, class_id=0, class_count=0, no_spike=0, busy=0, err_late=0.
  - rst overrides every other input, including mid-ACCUM or mid-SCAN.
- States: IDLE, ACCUM, SCAN, REPORT.
- start_core_img=1, in any state:
  - Clear counters, tu_cnt, class_id, class_count, no_spike and err_late.
  - Next state = ACCUM.
  - Any valid_op_nub in the same cycle is dropped: not counted, no error.
- ACCUM, on valid_op_nub=1:
  - For every i with spike_op_nub[i]=1, counter i increments, saturating at 2^CNT_W-1 (no wrap).
  - tu_cnt increments.
  - If this is valid number T_STEPS (tu_cnt == T_STEPS-1 before the increment), next state = SCAN and scan index = 0.
  - busy=1.
- ACCUM, valid_op_nub=0: hold.
- SCAN: one counter per cycle, index 0..N-1.
  - best_cnt/best_id are initialised to 0 at entry.
  - Update only when cnt[idx] > best_cnt (strict), so the lowest index wins a tie.
  - After idx N-1 is processed, next state = REPORT. busy=1.
- REPORT, for exactly one cycle:
  - class_valid=1.
  - class_id=best_id, class_count=best_cnt.
  - no_spike = (best_cnt==0); in that case class_id=0.
  - Next state = IDLE, busy=0.
- Latency: if the final valid is sampled at edge E, class_valid is high during the cycle after edge E+N+1. The pulse lasts one cycle.
- class_id, class_count, no_spike and spike_counts hold their values until the next start_core_img or rst.
- valid_op_nub=1 in IDLE, SCAN or REPORT:
  - Ignored for counting.
  - Sets err_late=1; it stays set until start_core_img or rst.
- A new start_core_img during SCAN aborts the scan. No class_valid is produced for the aborted image.
- spike_op_nub is sampled only when valid_op_nub=1.

Test Plan:
- T_STEPS=4, N=8:
  - Stimulus: start; 4 valids with neuron 5 spiking every step and neuron 2 on steps 1–2.
  - Required: class_valid one cycle after edge E+9; class_id=5, class_count=4, no_spike=0, busy low afterwards.
- Tie:
  - Stimulus: neurons 3 and 6 each spike 3 times in 4 steps.
  - Required: class_id=3, class_count=3.
- No activity:
  - Stimulus: 4 valids with spike_op_nub=0.
  - Required: class_valid pulse, no_spike=1, class_id=0, class_count=0.
- Saturation:
  - Stimulus: CNT_W=2, T_STEPS=5, neuron 1 spikes every step.
  - Required: counter 1 = 3 (no wrap), class_id=1, class_count=3.
- Restart and late valid:
  - Stimulus: start_core_img after 2 valids → counters clear and tu_cnt=0; the window completes only after 4 further valids.
  - Stimulus: valid_op_nub in IDLE → err_late=1, counters unchanged.
  - Stimulus: start_core_img coinciding with valid_op_nub → valid dropped, err_late=0.
- Reset mid-SCAN:
  - Stimulus: assert rst mid-SCAN.
  - Required: next cycle all outputs 0, state IDLE, no class_valid.
